// File: rtl/move_controller.sv
// Connect-Four move sequencer: drops a piece, owns the board and turn,
// and qualifies the external win checker's flags against the board edges.
module move_controller #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   new_game,
  input  logic                   move_valid,
  input  logic [COL_BITS-1:0]    move_col,
  output logic                   move_ready,
  output logic [ROWS*COLS*2-1:0] board_vec,
  output logic [ROW_BITS-1:0]    check_row,
  output logic [COL_BITS-1:0]    check_col,
  output logic [1:0]             check_player,
  input  logic [12:0]            win_flags,
  output logic [1:0]             current_player,
  output logic [6:0]             move_count,
  output logic                   done_valid,
  output logic [1:0]             done_code,
  output logic                   game_over,
  output logic [1:0]             winner
);

  localparam int CELLS = ROWS * COLS;

  typedef enum logic [1:0] {IDLE, SCAN, PLACE, CHECK} state_t;

  state_t                state;
  state_t                state_nx;
  logic [CELLS*2-1:0]    board;
  logic [ROW_BITS-1:0]   scan_row;
  logic [COL_BITS-1:0]   col_q;
  logic [12:0]           mask;
  logic                  cell_empty;
  logic                  last_row;
  logic                  hit;
  logic                  full;
  logic                  fire;
  logic [1:0]            code;
  int                    sel;
  int                    mr;
  int                    mc;

  assign move_ready   = (state == IDLE) && !game_over;
  assign board_vec    = board;
  assign check_player = current_player;

  always_comb begin
    sel        = int'(scan_row) * COLS + int'(col_q);
    cell_empty = (board[sel*2 +: 2] == 2'b00);
    last_row   = (int'(scan_row) == ROWS - 1);
    full       = (int'(move_count) == CELLS);
  end

  // A flag only counts if its whole 4-cell window lies on the board,
  // since the checker's indices wrap around the edges.
  always_comb begin
    mask    = '0;
    mr      = int'(check_row);
    mc      = int'(check_col);
    mask[0] = (mr >= 3);
    for (int k = 1; k <= 4; k++) begin
      mask[k]   = (mc >= 4 - k) && (mc + k - 1 <= COLS - 1);
      mask[4+k] = (mc >= 4 - k) && (mr + 4 - k <= ROWS - 1)
               && (mr >= k - 1) && (mc + k - 1 <= COLS - 1);
      mask[8+k] = (mr >= 4 - k) && (mc >= 4 - k)
               && (mr + k - 1 <= ROWS - 1) && (mc + k - 1 <= COLS - 1);
    end
    hit = |(win_flags & mask);
  end

  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    code     = 2'b00;
    unique case (state)
      IDLE: begin
        if (move_valid && move_ready) begin
          if (int'(move_col) >= COLS) begin
            fire = 1'b1;
            code = 2'b01;
          end else begin
            state_nx = SCAN;
          end
        end
      end
      SCAN: begin
        if (cell_empty) begin
          state_nx = PLACE;
        end else if (last_row) begin
          fire     = 1'b1;
          code     = 2'b01;
          state_nx = IDLE;
        end
      end
      PLACE: state_nx = CHECK;
      CHECK: begin
        fire     = 1'b1;
        state_nx = IDLE;
        if (hit)       code = 2'b10;
        else if (full) code = 2'b11;
        else           code = 2'b00;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state <= IDLE;
    else if (new_game) state <= IDLE;
    else               state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board          <= '0;
      current_player <= 2'b01;
      move_count     <= '0;
      game_over      <= 1'b0;
      winner         <= 2'b00;
      done_valid     <= 1'b0;
      done_code      <= 2'b00;
      check_row      <= '0;
      check_col      <= '0;
      scan_row       <= '0;
      col_q          <= '0;
    end else if (new_game) begin
      board          <= '0;
      current_player <= 2'b01;
      move_count     <= '0;
      game_over      <= 1'b0;
      winner         <= 2'b00;
      done_valid     <= 1'b0;
      done_code      <= 2'b00;
      check_row      <= '0;
      check_col      <= '0;
      scan_row       <= '0;
      col_q          <= '0;
    end else begin
      done_valid <= fire;
      if (fire) done_code <= code;
      unique case (state)
        IDLE: begin
          if (move_valid && move_ready) begin
            col_q    <= move_col;
            scan_row <= '0;
          end
        end
        SCAN: begin
          if (!cell_empty && !last_row) scan_row <= scan_row + 1'b1;
        end
        PLACE: begin
          board[sel*2 +: 2] <= current_player;
          check_row         <= scan_row;
          check_col         <= col_q;
          move_count        <= move_count + 1'b1;
        end
        CHECK: begin
          if (hit) begin
            game_over <= 1'b1;
            winner    <= current_player;
          end else if (full) begin
            game_over <= 1'b1;
            winner    <= 2'b00;
          end else begin
            current_player <= {current_player[0], current_player[1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Scoreboard bench for move_controller: a board-level game model predicts
// each result; a wrapping win-checker model drives win_flags.
module tb_move_controller;
  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         new_game = 1'b0;
  logic         move_valid = 1'b0;
  logic [2:0]   move_col = '0;
  logic         move_ready;
  logic [127:0] board_vec;
  logic [2:0]   check_row;
  logic [2:0]   check_col;
  logic [1:0]   check_player;
  logic [12:0]  win_flags;
  logic [1:0]   current_player;
  logic [6:0]   move_count;
  logic         done_valid;
  logic [1:0]   done_code;
  logic         game_over;
  logic [1:0]   winner;

  move_controller dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game),
    .move_valid(move_valid), .move_col(move_col),
    .move_ready(move_ready), .board_vec(board_vec),
    .check_row(check_row), .check_col(check_col),
    .check_player(check_player), .win_flags(win_flags),
    .current_player(current_player), .move_count(move_count),
    .done_valid(done_valid), .done_code(done_code),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit hold_zero = 1'b0;

  typedef struct {
    logic [1:0]   code;
    int           due;
    logic [127:0] brd;
    int           pl;
    int           cnt;
    int           over;
    int           win;
    int           cr;
    int           cc;
  } exp_t;

  exp_t sbq[$];

  int bm[ROWS][COLS];
  int pl, cnt, over, wnr, lcr, lcc;

  function automatic void chk(input string nm, input logic [127:0] act,
                              input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // Win checker as the real one behaves: indices wrap modulo 8.
  function automatic logic [12:0] wrap_flags(input logic [127:0] b,
      input logic [2:0] r0, input logic [2:0] c0, input logic [1:0] p);
    logic [12:0] f;
    int r, c, a;
    f = '0;
    r = int'(r0);
    c = int'(c0);
    f[0] = 1'b1;
    for (int j = 0; j < 4; j++)
      if (b[(((r - j) & 7) * 8 + (c & 7)) * 2 +: 2] != p) f[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      a = 4 - k;
      f[k] = 1'b1; f[4+k] = 1'b1; f[8+k] = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (b[((r & 7) * 8 + ((c - a + j) & 7)) * 2 +: 2] != p)
          f[k] = 1'b0;
        if (b[(((r + a - j) & 7) * 8 + ((c - a + j) & 7)) * 2 +: 2] != p)
          f[4+k] = 1'b0;
        if (b[(((r - a + j) & 7) * 8 + ((c - a + j) & 7)) * 2 +: 2] != p)
          f[8+k] = 1'b0;
      end
    end
    if (p == 2'b00) f = '0;
    return f;
  endfunction

  assign win_flags = hold_zero ? 13'd0
    : wrap_flags(board_vec, check_row, check_col, check_player);

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) bm[r][c] = 0;
    pl = 1; cnt = 0; over = 0; wnr = 0; lcr = 0; lcc = 0;
  endfunction

  function automatic logic [127:0] pack_board();
    logic [127:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[(r * COLS + c) * 2 +: 2] = 2'(bm[r][c]);
    return v;
  endfunction

  // True four-in-a-row through (r,c) in any direction, on-board only.
  function automatic bit won(input int r, input int c);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    int n, rr, cc;
    for (int d = 0; d < 4; d++) begin
      n = 1;
      for (int s = -1; s <= 1; s += 2) begin
        rr = r + s * dr[d];
        cc = c + s * dc[d];
        while (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS
               && bm[rr][cc] == pl) begin
          n++;
          rr += s * dr[d];
          cc += s * dc[d];
        end
      end
      if (n >= 4) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void predict(input int col, input int hs);
    exp_t e;
    int r;
    r = -1;
    for (int i = ROWS - 1; i >= 0; i--) if (bm[i][col] == 0) r = i;
    if (r < 0) begin
      e.code = 2'b01;
      e.due  = hs + ROWS + 1;
    end else begin
      bm[r][col] = pl;
      cnt++;
      lcr = r;
      lcc = col;
      e.due = hs + r + 4;
      if (!hold_zero && won(r, col)) begin
        e.code = 2'b10; over = 1; wnr = pl;
      end else if (cnt == ROWS * COLS) begin
        e.code = 2'b11; over = 1; wnr = 0;
      end else begin
        e.code = 2'b00; pl = 3 - pl;
      end
    end
    e.brd = pack_board();
    e.pl = pl; e.cnt = cnt; e.over = over; e.win = wnr;
    e.cr = lcr; e.cc = lcc;
    sbq.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got code %0d want none", done_code);
      end else begin
        e = sbq.pop_front();
        chk("done_code", done_code, e.code);
        chk("done_cycle", cyc, e.due);
        chk("board_vec", board_vec, e.brd);
        chk("current_player", current_player, e.pl);
        chk("move_count", move_count, e.cnt);
        chk("game_over", game_over, e.over);
        chk("winner", winner, e.win);
        chk("check_row", check_row, e.cr);
        chk("check_col", check_col, e.cc);
        chk("move_ready", move_ready, e.over == 0);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (move_ready) begin
        ok = 1'b1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL ready_timeout: got 0 want 1");
  endtask

  task automatic do_move(input int col);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    predict(col, cyc);
    move_valid = 1'b1;
    move_col   = 3'(col);
    @(posedge clk);
    #1 move_valid = 1'b0;
  endtask

  task automatic raw_move(input int col);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    move_valid = 1'b1;
    move_col   = 3'(col);
    @(posedge clk);
    #1 move_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (sbq.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
    sbq.delete();
  endtask

  task automatic do_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_board"}, board_vec, 0);
    chk({tag, "_player"}, current_player, 1);
    chk({tag, "_count"}, move_count, 0);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_winner"}, winner, 0);
    chk({tag, "_done_valid"}, done_valid, 0);
    chk({tag, "_done_code"}, done_code, 0);
    chk({tag, "_check_row"}, check_row, 0);
    chk({tag, "_check_col"}, check_col, 0);
    chk({tag, "_ready"}, move_ready, 1);
  endtask

  task automatic no_pulse(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, done_valid, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq_win[7] = '{0, 7, 1, 7, 2, 7, 3};
    int seq_wrap[7] = '{0, 0, 1, 1, 2, 2, 7};
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("after_reset");

    do_move(3);
    wait_drain();

    do_new_game();
    for (int i = 0; i < 9; i++) do_move(5);
    wait_drain();

    do_new_game();
    for (int i = 0; i < 7; i++) do_move(seq_win[i]);
    wait_drain();
    chk("win_over", game_over, 1);
    @(negedge clk);
    move_valid = 1'b1;
    move_col   = 3'd4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ignored_ready", move_ready, 0);
      chk("ignored_board", board_vec, pack_board());
      chk("ignored_done", done_valid, 0);
    end
    move_valid = 1'b0;

    do_new_game();
    for (int i = 0; i < 7; i++) do_move(seq_wrap[i]);
    wait_drain();

    do_new_game();
    hold_zero = 1'b1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) do_move(c);
    wait_drain();
    hold_zero = 1'b0;

    do_new_game();
    for (int i = 0; i < 3; i++) do_move(4);
    wait_drain();
    raw_move(4);
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_reset();
    no_pulse("abort_scan_pulse", 8);
    check_reset_vals("abort_scan");
    do_move(3);
    wait_drain();

    @(negedge clk);
    move_valid = 1'b1;
    new_game   = 1'b1;
    move_col   = 3'd6;
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    new_game   = 1'b0;
    model_reset();
    no_pulse("same_cycle_pulse", 6);
    check_reset_vals("same_cycle");

    raw_move(2);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_vals("rst_check");
    @(negedge clk);
    rst_n = 1'b1;
    no_pulse("rst_check_pulse", 6);
    do_move(2);
    wait_drain();

    for (int g = 0; g < 4; g++) begin
      do_new_game();
      for (int n = 0; n < 80 && over == 0; n++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_move(int'($urandom_range(0, COLS - 1)));
      end
      wait_drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
